// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// grant identities and the control register address.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 7;
  localparam int DEPTH_DEF  = 64;

  localparam logic [6:0] CTRL_ADDR = 7'h7F;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    APB_RD   = 2'd1,
    APB_RESP = 2'd2
  } state_t;

  typedef enum logic {
    STRM = 1'b0,
    APB  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter: on a conflict the loser of the previous
// conflict wins; the last-grant register moves only when both request.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic req_strm,
  input  logic req_apb,
  output logic gnt_strm,
  output logic gnt_apb
);

  grant_t last_reg;

  always_comb begin
    gnt_strm = req_strm && (!req_apb || (last_reg == APB));
    gnt_apb  = req_apb && (!req_strm || (last_reg == STRM));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      last_reg <= STRM;
    end else if (req_strm && req_apb) begin
      last_reg <= gnt_apb ? APB : STRM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between a sequential stream writer and an
// APB slave; owns the stream write pointer, the full flag and a CTRL register.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              res,
  input  logic              strm_valid,
  input  logic [DATA_W-1:0] strm_data,
  output logic              strm_ready,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_full,
  output logic [ADDR_W-1:0] wr_ptr
);

  localparam logic [ADDR_W-1:0] CTRL_A    = ADDR_W'(CTRL_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              mem_full_reg;
  logic [DATA_W-1:0] prdata_reg;
  logic              pready_reg;
  logic              pslverr_reg;

  logic apb_req, addr_is_mem, addr_is_ctrl, apb_mem_req, apb_ctrl_req;
  logic strm_req, gnt_strm, gnt_apb, strm_grant, apb_mem_grant;

  always_comb begin
    apb_req      = psel && penable && (state_reg == IDLE);
    addr_is_mem  = (paddr < DEPTH_A);
    addr_is_ctrl = (paddr == CTRL_A);
    apb_mem_req  = apb_req && addr_is_mem;
    apb_ctrl_req = apb_req && addr_is_ctrl;
    // A CTRL access holds the stream off so a clear never meets an increment.
    strm_req     = strm_valid && !mem_full_reg && !apb_ctrl_req;
  end

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .res      (res),
    .req_strm (strm_req),
    .req_apb  (apb_mem_req),
    .gnt_strm (gnt_strm),
    .gnt_apb  (gnt_apb)
  );

  always_comb begin
    strm_grant    = gnt_strm && res;
    apb_mem_grant = gnt_apb && res;
    strm_ready    = strm_grant;
    mem_en        = strm_grant || apb_mem_grant;
    mem_we        = strm_grant || (apb_mem_grant && pwrite);
    mem_addr      = '0;
    mem_wdata     = '0;
    if (strm_grant) begin
      mem_addr  = wr_ptr_reg;
      mem_wdata = strm_data;
    end else if (apb_mem_grant) begin
      mem_addr  = paddr;
      mem_wdata = pwdata;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      mem_full_reg <= 1'b0;
      prdata_reg   <= '0;
      pready_reg   <= 1'b0;
      pslverr_reg  <= 1'b0;
    end else begin
      pready_reg <= 1'b0;
      if (strm_grant) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (wr_ptr_reg == LAST_ADDR) mem_full_reg <= 1'b1;
      end
      unique case (state_reg)
        IDLE: begin
          if (apb_mem_grant) begin
            state_reg   <= pwrite ? APB_RESP : APB_RD;
            pready_reg  <= pwrite;
            pslverr_reg <= 1'b0;
          end else if (apb_ctrl_req) begin
            if (pwrite) begin
              if (pwdata[0]) begin
                wr_ptr_reg   <= '0;
                mem_full_reg <= 1'b0;
              end
            end else begin
              prdata_reg <= DATA_W'({mem_full_reg, wr_ptr_reg});
            end
            state_reg   <= APB_RESP;
            pready_reg  <= 1'b1;
            pslverr_reg <= 1'b0;
          end else if (apb_req && !addr_is_mem) begin
            state_reg   <= APB_RESP;
            pready_reg  <= 1'b1;
            pslverr_reg <= 1'b1;
          end
        end
        APB_RD: begin
          prdata_reg <= mem_rdata;
          pready_reg <= 1'b1;
          state_reg  <= APB_RESP;
        end
        APB_RESP: begin
          pslverr_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign prdata   = prdata_reg;
  assign pready   = pready_reg;
  assign pslverr  = pslverr_reg;
  assign mem_full = mem_full_reg;
  assign wr_ptr   = wr_ptr_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, write scoreboard and directed
// stream / APB / conflict / reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic        strm_valid;
  logic [31:0] strm_data;
  logic        strm_ready;
  logic        psel, penable, pwrite;
  logic [6:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_full;
  logic [6:0]  wr_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_en_cnt = 0;
  logic [38:0] sb_q[$];
  logic [31:0] mem_model [0:127];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .res(res),
    .strm_valid(strm_valid), .strm_data(strm_data), .strm_ready(strm_ready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_full(mem_full), .wr_ptr(wr_ptr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Registered-read memory macro model.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  always @(negedge clk) begin
    logic [38:0] e;
    if (res && mem_en) begin
      mem_en_cnt++;
      if (mem_we) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_write", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e[38:32]));
          check("wr_data", mem_wdata, e[31:0]);
          $display("[TB] mem write addr=%0d data=0x%08h", mem_addr, mem_wdata);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [6:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err, output int cyc);
    logic got;
    step();
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    step();
    penable = 1'b1;
    cyc = 0; rd = '0; err = 1'b0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (pready) begin
        rd = prdata; err = pslverr; got = 1'b1;
        break;
      end
    end
    if (!got) cyc = 99;
    $display("[TB] apb %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0b cycles=%0d",
             wr ? "WR" : "RD", a, d, rd, err, cyc);
    step();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          cnt0;

    res = 1'b0; strm_valid = 1'b1; strm_data = 32'h0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready", 32'(pready), 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rst_mem_full", 32'(mem_full), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_strm_ready", 32'(strm_ready), 32'd0);
    step();
    strm_valid = 1'b0;
    res = 1'b1;

    // Stream fills memory at one word per cycle.
    for (int i = 0; i < 64; i++) begin
      step();
      strm_valid = 1'b1;
      strm_data  = 32'h100 + 32'(i);
      sb_q.push_back({7'(i), strm_data});
      @(negedge clk);
      check("strm_ready_fill", 32'(strm_ready), 32'd1);
      check("wr_ptr_fill", 32'(wr_ptr), 32'(i));
    end
    step();
    strm_data = 32'h140;
    @(negedge clk);
    check("full_strm_ready", 32'(strm_ready), 32'd0);
    check("full_flag", 32'(mem_full), 32'd1);
    check("full_wr_ptr", 32'(wr_ptr), 32'd64);
    check("full_mem_en", 32'(mem_en), 32'd0);
    step();
    strm_valid = 1'b0;

    // APB write then read back.
    sb_q.push_back({7'd5, 32'hDEADBEEF});
    apb_xfer(1'b1, 7'd5, 32'hDEADBEEF, rd, err, cyc);
    check("apb_wr_cycles", 32'(cyc), 32'd2);
    check("apb_wr_err", 32'(err), 32'd0);
    apb_xfer(1'b0, 7'd5, 32'h0, rd, err, cyc);
    check("apb_rd_cycles", 32'(cyc), 32'd3);
    check("apb_rd_data", rd, 32'hDEADBEEF);
    check("apb_rd_err", 32'(err), 32'd0);

    // Unmapped address errors without touching memory.
    cnt0 = mem_en_cnt;
    apb_xfer(1'b0, 7'h50, 32'h0, rd, err, cyc);
    check("err_pslverr", 32'(err), 32'd1);
    check("err_cycles", 32'(cyc), 32'd2);
    check("err_no_mem_en", 32'(mem_en_cnt - cnt0), 32'd0);

    // CTRL status while full, clear, then status and stream resume.
    apb_xfer(1'b0, 7'h7F, 32'h0, rd, err, cyc);
    check("ctrl_rd_full", rd, 32'h000000C0);
    check("ctrl_rd_cycles", 32'(cyc), 32'd2);
    apb_xfer(1'b1, 7'h7F, 32'h1, rd, err, cyc);
    check("ctrl_wr_cycles", 32'(cyc), 32'd2);
    check("ctrl_wr_err", 32'(err), 32'd0);
    check("clr_mem_full", 32'(mem_full), 32'd0);
    check("clr_wr_ptr", 32'(wr_ptr), 32'd0);
    apb_xfer(1'b0, 7'h7F, 32'h0, rd, err, cyc);
    check("ctrl_rd_clear", rd, 32'h00000000);
    step();
    strm_valid = 1'b1; strm_data = 32'h200;
    sb_q.push_back({7'd0, 32'h200});
    @(negedge clk);
    check("resume_ready", 32'(strm_ready), 32'd1);
    check("resume_addr", 32'(mem_addr), 32'd0);
    step();
    strm_valid = 1'b0;
    check("resume_wr_ptr", 32'(wr_ptr), 32'd1);

    // First conflict: APB wins, stream follows in the response cycle.
    step();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'd10; pwdata = 32'hA0A0A0A0;
    step();
    penable = 1'b1; strm_valid = 1'b1; strm_data = 32'h51515151;
    sb_q.push_back({7'd10, 32'hA0A0A0A0});
    sb_q.push_back({7'd1, 32'h51515151});
    @(negedge clk);
    check("c1_strm_wait", 32'(strm_ready), 32'd0);
    check("c1_apb_addr", 32'(mem_addr), 32'd10);
    @(negedge clk);
    check("c1_strm_go", 32'(strm_ready), 32'd1);
    check("c1_pready", 32'(pready), 32'd1);
    step();
    psel = 1'b0; penable = 1'b0; strm_valid = 1'b0;

    // Second conflict: stream wins, APB delayed one cycle.
    step();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'd11; pwdata = 32'hB0B0B0B0;
    step();
    penable = 1'b1; strm_valid = 1'b1; strm_data = 32'h52525252;
    sb_q.push_back({7'd2, 32'h52525252});
    sb_q.push_back({7'd11, 32'hB0B0B0B0});
    @(negedge clk);
    check("c2_strm_go", 32'(strm_ready), 32'd1);
    check("c2_strm_addr", 32'(mem_addr), 32'd2);
    step();
    strm_valid = 1'b0;
    @(negedge clk);
    check("c2_apb_addr", 32'(mem_addr), 32'd11);
    check("c2_pready_early", 32'(pready), 32'd0);
    @(negedge clk);
    check("c2_pready", 32'(pready), 32'd1);
    step();
    psel = 1'b0; penable = 1'b0;
    apb_xfer(1'b0, 7'd10, 32'h0, rd, err, cyc);
    check("c1_readback", rd, 32'hA0A0A0A0);
    apb_xfer(1'b0, 7'd11, 32'h0, rd, err, cyc);
    check("c2_readback", rd, 32'hB0B0B0B0);

    // Reset while the read sits in APB_RD.
    step();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 7'd5;
    step();
    penable = 1'b1;
    @(negedge clk);
    check("rr_mem_rd", 32'({mem_en, mem_we}), 32'b10);
    step();
    res = 1'b0; strm_valid = 1'b1;
    @(negedge clk);
    check("rr_mem_en", 32'(mem_en), 32'd0);
    check("rr_strm_ready", 32'(strm_ready), 32'd0);
    check("rr_wr_ptr", 32'(wr_ptr), 32'd0);
    check("rr_mem_full", 32'(mem_full), 32'd0);
    check("rr_prdata", prdata, 32'd0);
    check("rr_pslverr", 32'(pslverr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("rr_pready", 32'(pready), 32'd0);
      @(negedge clk);
    end
    psel = 1'b0; penable = 1'b0; strm_valid = 1'b0;
    step();
    res = 1'b1;
    sb_q.push_back({7'd20, 32'h00000055});
    apb_xfer(1'b1, 7'd20, 32'h55, rd, err, cyc);
    check("post_rst_wr_cycles", 32'(cyc), 32'd2);

    repeat (2) step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
